// File: rtl/rf_pkg.sv
// Shared types and constants for the writeback register file.
// Holds register count/width, the null index and the index type.
package rf_pkg;

    localparam int NREG  = 7;
    localparam int WIDTH = 16;
    localparam int IDX_W = 3;
    localparam int IDX_SPAN = 1 << IDX_W;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t NULL_ADDR = 3'b111;

    // True for any index that names real storage.
    function automatic logic is_real_reg(input reg_idx_t idx);
        return idx != NULL_ADDR;
    endfunction

endpackage

// File: rtl/reg_file_wb_if.sv
// Writeback / issue bundle of the register file.
// master: writeback and decode side; slave: the register file.
interface reg_file_wb_if #(
    parameter int NREG  = rf_pkg::NREG,
    parameter int WIDTH = rf_pkg::WIDTH
);
    import rf_pkg::*;

    logic                  wb_valid;
    reg_idx_t              dest_address_wb;
    logic [WIDTH-1:0]      data_wb;
    logic                  issue_valid;
    reg_idx_t              issue_dest;
    reg_idx_t              issue_src_a;
    reg_idx_t              issue_src_b;
    logic [NREG*WIDTH-1:0] raw_data_112;
    logic [NREG-1:0]       busy;
    logic                  stall;
    logic [15:0]           wb_count;

    modport master (
        output wb_valid,
        output dest_address_wb,
        output data_wb,
        output issue_valid,
        output issue_dest,
        output issue_src_a,
        output issue_src_b,
        input  raw_data_112,
        input  busy,
        input  stall,
        input  wb_count
    );

    modport slave (
        input  wb_valid,
        input  dest_address_wb,
        input  data_wb,
        input  issue_valid,
        input  issue_dest,
        input  issue_src_a,
        input  issue_src_b,
        output raw_data_112,
        output busy,
        output stall,
        output wb_count
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: per-register busy bits and issue stall.
// Ports: clk/rst, writeback and issue requests in; busy, stall out.
module reg_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = rf_pkg::NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  reg_idx_t        wb_dest,
    input  logic            issue_valid,
    input  reg_idx_t        issue_dest,
    input  reg_idx_t        src_a,
    input  reg_idx_t        src_b,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    logic [IDX_SPAN-1:0] busy_ext;
    logic [IDX_SPAN-1:0] hz;
    logic [IDX_SPAN-1:0] clr;
    logic [IDX_SPAN-1:0] set;
    logic [IDX_SPAN-1:0] busy_n;
    logic                accept;

    // Busy is widened to cover every index value so the 3-bit
    // selects below never fall outside the vector.
    always_comb begin
        busy_ext = '0;
        busy_ext[NREG-1:0] = busy;
    end

    // A writeback landing this cycle resolves the hazard on its
    // register; the consumer picks the value up downstream.
    always_comb begin
        hz = '0;
        for (int i = 0; i < IDX_SPAN; i++) begin
            hz[i] = busy_ext[i]
                  && is_real_reg(reg_idx_t'(i))
                  && !(wb_valid && wb_dest == reg_idx_t'(i));
        end
    end

    always_comb begin
        stall = issue_valid
              & (hz[src_a] | hz[src_b] | hz[issue_dest]);
    end

    assign accept = issue_valid & ~stall;

    always_comb begin
        clr = '0;
        set = '0;
        if (wb_valid && is_real_reg(wb_dest))
            clr[wb_dest] = 1'b1;
        if (accept && is_real_reg(issue_dest))
            set[issue_dest] = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue keeps busy.
    assign busy_n = (busy_ext & ~clr) | set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_n[NREG-1:0];
    end

endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with writeback port and write counter.
// Ports: clk, rst, bus (slave): writeback/issue in; raw data, busy, stall, count out.
module reg_file_wb
    import rf_pkg::*;
#(
    parameter int NREG  = rf_pkg::NREG,
    parameter int WIDTH = rf_pkg::WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_wb_if.slave  bus
);

    logic [WIDTH-1:0] regs [NREG];
    logic [15:0]      cnt;
    logic [NREG-1:0]  busy;
    logic             stall;
    logic             wr_en;

    assign wr_en = bus.wb_valid
                && is_real_reg(bus.dest_address_wb)
                && (int'(bus.dest_address_wb) < NREG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            cnt <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_en && bus.dest_address_wb == reg_idx_t'(i))
                    regs[i] <= bus.data_wb;
            end
            if (wr_en)
                cnt <= cnt + 16'd1;
        end
    end

    reg_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (bus.wb_valid),
        .wb_dest     (bus.dest_address_wb),
        .issue_valid (bus.issue_valid),
        .issue_dest  (bus.issue_dest),
        .src_a       (bus.issue_src_a),
        .src_b       (bus.issue_src_b),
        .busy        (busy),
        .stall       (stall)
    );

    // No read bypass: a write shows up the cycle after it lands.
    for (genvar g = 0; g < NREG; g++) begin : g_raw
        assign bus.raw_data_112[g*WIDTH +: WIDTH] = regs[g];
    end

    assign bus.busy     = busy;
    assign bus.stall    = stall;
    assign bus.wb_count = cnt;

endmodule

// File: tb/tb_reg_file_wb.sv
// Scoreboard bench for reg_file_wb: directed steps push expectations,
// a negedge monitor pops and compares them.
module tb_reg_file_wb;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_file_wb_if bus ();

    reg_file_wb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string          name;
        logic           stall;
        logic [111:0]   raw;
        logic [6:0]     busy;
        logic [15:0]    cnt;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [111:0] pack7(
        input logic [15:0] r0, r1, r2, r3, r4, r5, r6
    );
        return {r6, r5, r4, r3, r2, r1, r0};
    endfunction

    task automatic check_field(
        input string nm, input string f,
        input logic [111:0] act, input logic [111:0] exp
    );
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, f, act, exp);
        end
    endtask

    // Monitor: outputs are sampled mid-cycle, after inputs settle.
    always @(negedge clk) begin : mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check_field(e.name, "stall", 112'(bus.stall), 112'(e.stall));
            check_field(e.name, "raw", bus.raw_data_112, e.raw);
            check_field(e.name, "busy", 112'(bus.busy), 112'(e.busy));
            check_field(e.name, "cnt", 112'(bus.wb_count), 112'(e.cnt));
        end
    end

    task automatic drive(
        input logic r, input logic wv, input logic [2:0] wd,
        input logic [15:0] wdat, input logic iv,
        input logic [2:0] id, input logic [2:0] sa, input logic [2:0] sb
    );
        @(posedge clk);
        #1;
        rst                 = r;
        bus.wb_valid        = wv;
        bus.dest_address_wb = wd;
        bus.data_wb         = wdat;
        bus.issue_valid     = iv;
        bus.issue_dest      = id;
        bus.issue_src_a     = sa;
        bus.issue_src_b     = sb;
    endtask

    task automatic step(
        input string nm,
        input logic r, input logic wv, input logic [2:0] wd,
        input logic [15:0] wdat, input logic iv,
        input logic [2:0] id, input logic [2:0] sa, input logic [2:0] sb,
        input logic es, input logic [111:0] er,
        input logic [6:0] eb, input logic [15:0] ec
    );
        exp_t e;
        drive(r, wv, wd, wdat, iv, id, sa, sb);
        e.name  = nm;
        e.stall = es;
        e.raw   = er;
        e.busy  = eb;
        e.cnt   = ec;
        q.push_back(e);
    endtask

    logic [111:0] ra, rb, rc, rd, re, rf, rg;

    initial begin
        rst                 = 1'b1;
        bus.wb_valid        = 1'b0;
        bus.dest_address_wb = '0;
        bus.data_wb         = '0;
        bus.issue_valid     = 1'b0;
        bus.issue_dest      = '0;
        bus.issue_src_a     = '0;
        bus.issue_src_b     = '0;

        ra = pack7(0, 0, 0, 0, 0, 16'h01FE, 0);
        rb = pack7(0, 0, 16'h1234, 0, 0, 16'h01FE, 0);
        rc = pack7(0, 0, 16'h1234, 16'h00AA, 0, 16'h01FE, 0);
        rd = pack7(0, 0, 16'h1234, 16'h00AA, 16'h4444, 16'h01FE, 0);
        re = pack7(16'hBEEF, 0, 0, 0, 0, 0, 0);
        rf = pack7(16'hBEEF, 16'hA5A5, 0, 0, 0, 0, 0);
        rg = pack7(16'hBEEF, 16'hA5A5, 0, 0, 0, 0, 16'h0006);

        step("reset",      1, 0, 0, 16'h0,    0, 0, 0, 0,
             0, '0, 7'b0000000, 16'd0);
        step("wb5",        0, 1, 5, 16'h01FE, 0, 0, 0, 0,
             0, '0, 7'b0000000, 16'd0);
        step("wb5_seen",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, ra, 7'b0000000, 16'd1);
        step("issue2",     0, 0, 0, 16'h0,    1, 2, 0, 1,
             0, ra, 7'b0000000, 16'd1);
        step("raw_stall",  0, 0, 0, 16'h0,    1, 4, 2, 0,
             1, ra, 7'b0000100, 16'd1);
        step("wb_unstall", 0, 1, 2, 16'h1234, 1, 4, 2, 0,
             0, ra, 7'b0000100, 16'd1);
        step("busy_moved", 0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rb, 7'b0010000, 16'd2);
        step("waw_stall",  0, 0, 0, 16'h0,    1, 4, 0, 0,
             1, rb, 7'b0010000, 16'd2);
        step("issue3",     0, 0, 0, 16'h0,    1, 3, 0, 0,
             0, rb, 7'b0010000, 16'd2);
        step("set_wins",   0, 1, 3, 16'h00AA, 1, 3, 0, 0,
             0, rb, 7'b0011000, 16'd2);
        step("set_kept",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rc, 7'b0011000, 16'd3);
        step("null_wb",    0, 1, 7, 16'hFFFF, 1, 7, 7, 7,
             0, rc, 7'b0011000, 16'd3);
        step("null_seen",  0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rc, 7'b0011000, 16'd3);
        step("wb4",        0, 1, 4, 16'h4444, 0, 0, 0, 0,
             0, rc, 7'b0011000, 16'd3);
        step("wb4_seen",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rd, 7'b0001000, 16'd4);
        step("srcb_stall", 0, 0, 0, 16'h0,    1, 0, 0, 3,
             1, rd, 7'b0001000, 16'd4);
        step("mid_rst",    1, 1, 1, 16'h5555, 0, 0, 0, 0,
             0, '0, 7'b0000000, 16'd0);
        step("rst_rel",    0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, '0, 7'b0000000, 16'd0);
        step("post_wb0",   0, 1, 0, 16'hBEEF, 0, 0, 0, 0,
             0, '0, 7'b0000000, 16'd0);
        step("wb0_seen",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, re, 7'b0000000, 16'd1);

        for (int i = 0; i < 65534; i++)
            drive(0, 1, 1, 16'hA5A5, 0, 0, 0, 0);

        step("cnt_ffff",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rf, 7'b0000000, 16'hFFFF);
        step("wb6",        0, 1, 6, 16'h0006, 0, 0, 0, 0,
             0, rf, 7'b0000000, 16'hFFFF);
        step("cnt_wrap",   0, 0, 0, 16'h0,    0, 0, 0, 0,
             0, rg, 7'b0000000, 16'h0000);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d expected=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
